// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine. Converts EX/MEM load/store
// controls into a req/ack data-bus transaction, stalls the pipeline while
// it is outstanding, lane-aligns store data and extends load data.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  me_writeMem,
  input  logic [2:0]  me_readMem,
  input  logic [31:0] me_outAlu,
  input  logic [31:0] me_rs2Data,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_wstrb,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       ld_type;   // 0 for stores: nothing to write back
  logic [1:0]       ld_off;

  logic        is_store;
  logic        is_load;
  logic        acc_valid;
  logic        misalign_now;
  logic        start;
  logic        ack_hit;
  logic        timeout_hit;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] lane;
  logic [31:0] ld_ext;

  // Decode the access and check natural alignment; a store overrides a load.
  always_comb begin
    is_store     = (me_writeMem != 2'b00);
    is_load      = !is_store && (me_readMem != 3'b000) && (me_readMem <= 3'b101);
    acc_valid    = is_store || is_load;
    misalign_now = 1'b0;
    if (is_store) begin
      case (me_writeMem)
        2'b10:   misalign_now = me_outAlu[0];
        2'b11:   misalign_now = |me_outAlu[1:0];
        default: misalign_now = 1'b0;
      endcase
    end else if (is_load) begin
      case (me_readMem)
        3'b010, 3'b101: misalign_now = me_outAlu[0];
        3'b011:         misalign_now = |me_outAlu[1:0];
        default:        misalign_now = 1'b0;
      endcase
    end
  end

  assign start       = (state == ST_IDLE) && acc_valid && !misalign_now;
  assign ack_hit     = (state == ST_WAIT) && dbus_ack;
  assign timeout_hit = (state == ST_WAIT) && !dbus_ack &&
                       (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mem_stall   = start || (state == ST_WAIT);

  // Place store bytes onto their lanes; reads carry no strobes.
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = 32'h0;
    case (me_writeMem)
      2'b01: begin
        st_wstrb = 4'b0001 << me_outAlu[1:0];
        st_wdata = {4{me_rs2Data[7:0]}};
      end
      2'b10: begin
        st_wstrb = 4'b0011 << {me_outAlu[1], 1'b0};
        st_wdata = {2{me_rs2Data[15:0]}};
      end
      2'b11: begin
        st_wstrb = 4'b1111;
        st_wdata = me_rs2Data;
      end
      default: begin
        st_wstrb = 4'b0000;
        st_wdata = 32'h0;
      end
    endcase
  end

  // Shift the addressed lane down and extend it according to the load type.
  always_comb begin
    lane   = dbus_rdata >> {ld_off, 3'b000};
    ld_ext = 32'h0;
    case (ld_type)
      3'b001:  ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'b010:  ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'b011:  ld_ext = dbus_rdata;
      3'b100:  ld_ext = {24'h0, lane[7:0]};
      3'b101:  ld_ext = {16'h0, lane[15:0]};
      default: ld_ext = 32'h0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // FSM next-state: issue, wait for ack or timeout, one DONE cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_WAIT;
      ST_WAIT: if (ack_hit || timeout_hit) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered bus request, result and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'h0;
      dbus_wdata <= 32'h0;
      dbus_wstrb <= 4'b0000;
      load_data  <= 32'h0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      cnt        <= '0;
      ld_type    <= 3'b000;
      ld_off     <= 2'b00;
    end else begin
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            dbus_req   <= 1'b1;
            dbus_we    <= is_store;
            dbus_addr  <= {me_outAlu[31:2], 2'b00};
            dbus_wdata <= st_wdata;
            dbus_wstrb <= st_wstrb;
            ld_type    <= is_store ? 3'b000 : me_readMem;
            ld_off     <= me_outAlu[1:0];
            cnt        <= '0;
          end else if (acc_valid) begin
            misaligned <= 1'b1;
            load_data  <= 32'h0;
          end
        end
        ST_WAIT: begin
          if (ack_hit) begin
            dbus_req <= 1'b0;
            if (ld_type != 3'b000) load_data <= ld_ext;
          end else if (timeout_hit) begin
            dbus_req  <= 1'b0;
            bus_err   <= 1'b1;
            load_data <= 32'h0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed transactions, a transaction-level
// expectation model checked every cycle, and literal spot checks.
`timescale 1ns/1ps
module tb_mem_access_unit;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  me_writeMem;
  logic [2:0]  me_readMem;
  logic [31:0] me_outAlu;
  logic [31:0] me_rs2Data;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        mem_stall;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_err;

  mem_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .me_writeMem(me_writeMem), .me_readMem(me_readMem),
    .me_outAlu(me_outAlu), .me_rs2Data(me_rs2Data),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .mem_stall(mem_stall), .load_data(load_data),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected outputs for the current cycle, maintained by the driver.
  logic        chk_en = 1'b0;
  logic        e_req = 1'b0, e_we = 1'b0, e_stall = 1'b0, e_mis = 1'b0, e_berr = 1'b0;
  logic        e_fields = 1'b0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_load = 0;
  logic [3:0]  e_wstrb = 0;
  logic [31:0] model_load = 0;

  // Activity counters and last request seen, for literal checks.
  int          stall_cnt = 0, req_cnt = 0, berr_cnt = 0, mis_cnt = 0;
  logic [31:0] seen_addr = 0, seen_wdata = 0;
  logic [3:0]  seen_wstrb = 0;
  logic        seen_we = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: byte enables from access size and offset.
  function automatic logic [3:0] m_wstrb(input logic [1:0] wm, input logic [1:0] off);
    logic [3:0] s;
    int o;
    s = 4'b0000;
    o = int'(off);
    for (int i = 0; i < 4; i++) begin
      case (wm)
        2'd1:    s[i] = (i == o);
        2'd2:    s[i] = ((i / 2) == (o / 2));
        2'd3:    s[i] = 1'b1;
        default: s[i] = 1'b0;
      endcase
    end
    return s;
  endfunction

  // Model: every lane carries the byte/half of the source it would hold.
  function automatic logic [31:0] m_wdata(input logic [1:0] wm, input logic [31:0] rs2);
    logic [31:0] d;
    d = 32'h0;
    for (int i = 0; i < 4; i++) begin
      case (wm)
        2'd1:    d[8*i +: 8] = rs2[7:0];
        2'd2:    d[8*i +: 8] = rs2[8*(i%2) +: 8];
        2'd3:    d[8*i +: 8] = rs2[8*i +: 8];
        default: d[8*i +: 8] = 8'h00;
      endcase
    end
    return d;
  endfunction

  // Model: load value via byte array and integer sign arithmetic.
  function automatic logic [31:0] m_load(input logic [2:0] rm, input logic [31:0] rd, input logic [1:0] off);
    int b[4];
    int o;
    int v;
    o = int'(off);
    for (int i = 0; i < 4; i++) b[i] = int'(rd[8*i +: 8]);
    v = 0;
    case (rm)
      3'd1: begin v = b[o]; if (v > 127) v = v - 256; end
      3'd4: v = b[o];
      3'd2: begin v = b[o+1] * 256 + b[o]; if (v > 32767) v = v - 65536; end
      3'd5: v = b[o+1] * 256 + b[o];
      3'd3: return rd;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  // Compare process: DUT against the expectations on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check32("dbus_req", {31'h0, dbus_req}, {31'h0, e_req});
      check32("mem_stall", {31'h0, mem_stall}, {31'h0, e_stall});
      check32("misaligned", {31'h0, misaligned}, {31'h0, e_mis});
      check32("bus_err", {31'h0, bus_err}, {31'h0, e_berr});
      check32("load_data", load_data, e_load);
      if (e_fields) begin
        check32("dbus_we", {31'h0, dbus_we}, {31'h0, e_we});
        check32("dbus_addr", dbus_addr, e_addr);
        check32("dbus_wstrb", {28'h0, dbus_wstrb}, {28'h0, e_wstrb});
        if (e_we) check32("dbus_wdata", dbus_wdata, e_wdata);
      end
    end
  end

  // Activity monitor.
  always @(negedge clk) begin
    if (mem_stall)  stall_cnt++;
    if (bus_err)    berr_cnt++;
    if (misaligned) mis_cnt++;
    if (dbus_req) begin
      req_cnt++;
      seen_addr  = dbus_addr;
      seen_wdata = dbus_wdata;
      seen_wstrb = dbus_wstrb;
      seen_we    = dbus_we;
    end
  end

  task automatic set_idle();
    me_writeMem = 2'b00;
    me_readMem  = 3'b000;
    me_outAlu   = 32'h0;
    me_rs2Data  = 32'h0;
    dbus_ack    = 1'b0;
    e_req = 0; e_stall = 0; e_mis = 0; e_berr = 0; e_fields = 0;
    e_load = model_load;
  endtask

  // One instruction in MEM. Called just after a rising edge.
  // ack_at: WAIT cycle (1-based) carrying the ack; 0 withholds it.
  task automatic access(input logic [1:0] wm, input logic [2:0] rm, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [31:0] rdata, input int ack_at,
                        input string tag);
    bit st, ld, acc, mis;
    int size, w;
    st   = (wm != 0);
    ld   = !st && (rm >= 1) && (rm <= 5);
    acc  = st || ld;
    if (st) size = (wm == 1) ? 1 : (wm == 2) ? 2 : 4;
    else    size = (rm == 1 || rm == 4) ? 1 : (rm == 2 || rm == 5) ? 2 : 4;
    mis  = acc && ((addr % size) != 0);
    me_writeMem = wm; me_readMem = rm; me_outAlu = addr; me_rs2Data = rs2;
    dbus_ack = 1'b0;
    e_req = 0; e_mis = 0; e_berr = 0; e_fields = 0; e_load = model_load;
    e_stall = acc && !mis;
    @(posedge clk); #1;
    if (mis) begin
      set_idle();
      model_load = 0;
      e_load = 0;
      e_mis = 1;
      @(posedge clk); #1;
      e_mis = 0;
    end else if (acc) begin
      w = (ack_at > 0) ? ack_at : TO;
      for (int k = 1; k <= w; k++) begin
        e_req = 1; e_stall = 1; e_fields = 1;
        e_we = st;
        e_addr = addr & 32'hFFFF_FFFC;
        e_wstrb = st ? m_wstrb(wm, addr[1:0]) : 4'b0000;
        e_wdata = m_wdata(wm, rs2);
        dbus_ack = (k == ack_at);
        dbus_rdata = (k == ack_at) ? rdata : $urandom;
        @(posedge clk); #1;
      end
      // DONE: a stray ack here must be ignored
      dbus_ack = 1'b1;
      dbus_rdata = ~rdata;
      e_req = 0; e_stall = 0; e_fields = 0;
      e_berr = (ack_at == 0);
      if (ack_at == 0) model_load = 0;
      else if (ld) model_load = m_load(rm, rdata, addr[1:0]);
      e_load = model_load;
      @(posedge clk); #1;
      set_idle();
      @(posedge clk); #1;
    end else begin
      set_idle();
      @(posedge clk); #1;
    end
    $display("txn %s wm=%0d rm=%0d addr=%h load_data=%h", tag, wm, rm, addr, load_data);
  endtask

  int s0, r0, b0, m0;

  task automatic snap();
    s0 = stall_cnt; r0 = req_cnt; b0 = berr_cnt; m0 = mis_cnt;
  endtask

  initial begin
    rst = 1'b0;
    dbus_rdata = 32'h0;
    set_idle();
    #12;
    check32("rst_req", {31'h0, dbus_req}, 32'h0);
    check32("rst_load", load_data, 32'h0);
    check32("rst_stall", {31'h0, mem_stall}, 32'h0);
    check32("rst_wstrb", {28'h0, dbus_wstrb}, 32'h0);
    #10 rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    snap();
    access(2'b01, 3'b000, 32'h0000_1003, 32'h1234_56AB, 32'h0, 1, "sb");
    check32("sb_stall_cycles", stall_cnt - s0, 2);
    check32("sb_req_cycles", req_cnt - r0, 1);
    check32("sb_addr", seen_addr, 32'h0000_1000);
    check32("sb_wstrb", {28'h0, seen_wstrb}, 32'h8);
    check32("sb_wdata", seen_wdata, 32'hABAB_ABAB);
    check32("sb_we", {31'h0, seen_we}, 32'h1);

    snap();
    access(2'b00, 3'b011, 32'h0000_3001, 32'h0, 32'h0, 1, "lw_mis");
    access(2'b10, 3'b000, 32'h0000_3003, 32'h5555_AAAA, 32'h0, 1, "sh_mis");
    check32("mis_pulses", mis_cnt - m0, 2);
    check32("mis_req", req_cnt - r0, 0);
    check32("mis_stall", stall_cnt - s0, 0);

    snap();
    access(2'b11, 3'b000, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 0, "sw_timeout");
    check32("to_req_cycles", req_cnt - r0, 16);
    check32("to_berr", berr_cnt - b0, 1);

    snap();
    access(2'b11, 3'b001, 32'h0000_0044, 32'h0BAD_CAFE, 32'h0, 16, "sw_ack16");
    check32("ack16_berr", berr_cnt - b0, 0);
    check32("ack16_req_cycles", req_cnt - r0, 16);

    snap();
    access(2'b00, 3'b001, 32'h0000_2002, 32'h0, 32'h0080_0000, 3, "lb");
    check32("lb_stall_cycles", stall_cnt - s0, 4);
    check32("lb_value", load_data, 32'hFFFF_FF80);
    access(2'b00, 3'b100, 32'h0000_2002, 32'h0, 32'h0080_0000, 3, "lbu");
    check32("lbu_value", load_data, 32'h0000_0080);
    access(2'b00, 3'b010, 32'h0000_2002, 32'h0, 32'h8001_1234, 1, "lh");
    check32("lh_value", load_data, 32'hFFFF_8001);
    access(2'b00, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_1234, 2, "lhu");
    check32("lhu_value", load_data, 32'h0000_8001);
    access(2'b01, 3'b000, 32'h0000_2001, 32'h0000_0077, 32'h0, 1, "sb_keeps_load");
    check32("store_keeps_load", load_data, 32'h0000_8001);
    access(2'b00, 3'b110, 32'h0000_2000, 32'h0, 32'h0, 1, "rm110_none");

    // Asynchronous reset in the middle of a WAIT
    chk_en = 1'b0;
    me_readMem = 3'b011; me_outAlu = 32'h0000_5000;
    dbus_ack = 1'b0; dbus_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    @(posedge clk); #3;
    check32("pre_rst_req", {31'h0, dbus_req}, 32'h1);
    set_idle();
    rst = 1'b0;
    #1;
    check32("async_rst_req", {31'h0, dbus_req}, 32'h0);
    check32("async_rst_stall", {31'h0, mem_stall}, 32'h0);
    check32("async_rst_load", load_data, 32'h0);
    model_load = 0;
    set_idle();
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    access(2'b00, 3'b011, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 1, "lw_after_rst");
    check32("lw_after_rst", load_data, 32'hDEAD_BEEF);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
